// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word reads, buffers
// in-order responses for decode, and applies redirects and syscall halt.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_cnt_q;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_base;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
  assign credit_used   = {1'b0, outstanding_q} + {1'b0, count};

  // Issue is held off during a redirect so the new target is simply pc next cycle.
  assign imem_req_valid = rst_n && (state_q == RUN) && (credit_used < CREDIT_LIMIT)
                          && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop        = !fifo_empty && out_ready;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req && !redirect_valid) state_d = HALTED;
      HALTED:  if (redirect_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight is stale, including a response landing now.
        pc_q       <= redirect_base;
        rsp_pc_q   <= redirect_base;
        drop_cnt_q <= outstanding_q - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (imem_rsp_valid) begin
          if (drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - CW'(1);
          else                  rsp_pc_q   <= rsp_pc_q + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against an epoch-tagged transaction model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  // Memory requests carry the redirect epoch they were issued in; old epochs are stale.
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] mbuf[$];
  int unsigned epoch;
  logic [31:0] fetch_pc;
  bit          m_halted;

  int total = 0;
  int bad = 0;

  int p_ready, p_rsp, p_oready, p_redir, p_halt;
  bit          f_redir, f_halt, aim_en;
  logic [31:0] f_redir_pc, aim_addr, aim_target;
  int          cyc, first_valid_cyc, fires;
  logic [31:0] last_fire_addr;
  logic [31:0] popped[$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFE0 + 32'($urandom_range(31));
    return 32'h0000_3000 + 32'($urandom_range(511));
  endfunction

  task automatic set_knobs(int r, int s, int o, int d, int h);
    p_ready = r; p_rsp = s; p_oready = o; p_redir = d; p_halt = h;
  endtask

  task automatic drive();
    imem_req_ready = ($urandom_range(99) < p_ready);
    imem_rsp_valid = (memq.size() > 0) && ($urandom_range(99) < p_rsp);
    imem_rsp_data  = imem_rsp_valid ? mem_word(memq[0].addr) : $urandom;
    out_ready      = ($urandom_range(99) < p_oready);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    halt_req       = 1'b0;
    if (f_redir) begin
      redirect_valid = 1'b1; redirect_pc = f_redir_pc; f_redir = 1'b0;
    end else if (aim_en && imem_rsp_valid && memq[0].addr == aim_addr) begin
      redirect_valid = 1'b1; redirect_pc = aim_target; aim_en = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1; redirect_pc = rand_target();
    end
    if (f_halt) begin
      halt_req = 1'b1; f_halt = 1'b0;
    end else if ($urandom_range(99) < p_halt) begin
      halt_req = 1'b1;
    end
  endtask

  task automatic step();
    bit    exp_rv;
    bit    rsp_live;
    mreq_t r;
    @(negedge clk);
    exp_rv = !m_halted && (memq.size() + mbuf.size() < 2) && !redirect_valid;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, fetch_pc);
    chk("out_valid", out_valid, mbuf.size() != 0);
    if (mbuf.size() != 0) begin
      chk("out_pc", out_pc, mbuf[0]);
      chk("out_instr", out_instr, mem_word(mbuf[0]));
    end
    chk("halted", halted, m_halted);

    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    cyc++;
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      last_fire_addr = imem_req_addr;
    end
    if (out_valid && out_ready) popped.push_back(out_pc);

    rsp_live = 1'b0;
    if (imem_rsp_valid) begin
      r = memq.pop_front();
      rsp_live = (r.epoch == epoch);
    end
    if (exp_rv && imem_req_ready) begin
      memq.push_back('{fetch_pc, epoch});
      fetch_pc += 32'd4;
    end
    if (out_ready && mbuf.size() != 0) void'(mbuf.pop_front());
    if (rsp_live) mbuf.push_back(r.addr);
    if (redirect_valid) begin
      mbuf.delete();
      epoch++;
      fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      m_halted = 1'b0;
    end else if (halt_req) begin
      m_halted = 1'b1;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    memq.delete(); mbuf.delete(); popped.delete();
    epoch = 0; fetch_pc = 32'h0000_3000; m_halted = 1'b0;
    f_redir = 1'b0; f_halt = 1'b0; aim_en = 1'b0;
    cyc = 0; first_valid_cyc = -1; fires = 0; last_fire_addr = 32'h1;
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic wait_fires(int n, int bound, string tag);
    int k = 0;
    while (fires < n && k < bound) begin step(); k++; end
    if (fires < n) chk(tag, fires, n);
  endtask

  task automatic wait_pops(int n, int bound, string tag);
    int k = 0;
    while (popped.size() < n && k < bound) begin step(); k++; end
    if (popped.size() < n) chk(tag, popped.size(), n);
  endtask

  task automatic wait_fire_addr(logic [31:0] a, int bound, string tag);
    int k = 0;
    int f0;
    bit hit = 1'b0;
    while (!hit && k < bound) begin
      f0 = fires;
      step();
      hit = (fires != f0) && (last_fire_addr == a);
      k++;
    end
    if (!hit) chk(tag, last_fire_addr, a);
  endtask

  initial begin
    int f0;
    int k;
    set_knobs(100, 100, 100, 0, 0);
    #1;

    // Streaming from reset with a zero-wait memory.
    do_reset();
    wait_pops(3, 40, "stream_timeout");
    chk("first_valid_cycle", first_valid_cyc, 2);
    if (popped.size() >= 3) begin
      chk("stream_pc0", popped[0], 32'h0000_3000);
      chk("stream_pc1", popped[1], 32'h0000_3004);
      chk("stream_pc2", popped[2], 32'h0000_3008);
    end

    // Decoder stall: credits cap requests at the buffer depth.
    set_knobs(100, 100, 0, 0, 0);
    do_reset();
    repeat (10) step();
    chk("stall_reqs", fires, 2);
    chk("stall_head", out_pc, 32'h0000_3000);
    p_oready = 100;
    wait_fires(3, 20, "resume_timeout");
    chk("resume_addr", last_fire_addr, 32'h0000_3008);

    // Redirect with two fetches in flight.
    set_knobs(100, 0, 100, 0, 0);
    do_reset();
    wait_fires(2, 20, "inflight_timeout");
    f_redir = 1'b1; f_redir_pc = 32'h0000_3040;
    step();
    step();
    popped.delete();
    p_rsp = 100;
    wait_pops(1, 40, "redir_timeout");
    if (popped.size() >= 1) chk("redir_first_pc", popped[0], 32'h0000_3040);

    // Response for 0x3008 lands in the redirect cycle.
    set_knobs(100, 100, 100, 0, 0);
    do_reset();
    aim_en = 1'b1; aim_addr = 32'h0000_3008; aim_target = 32'h0000_3100;
    k = 0;
    while (aim_en && k < 40) begin step(); k++; end
    if (aim_en) chk("aim_timeout", 32'(aim_en), 32'h0);
    step();
    popped.delete();
    wait_pops(1, 40, "aim_pop_timeout");
    if (popped.size() >= 1) chk("aim_first_pc", popped[0], 32'h0000_3100);

    // Halt after 0x3010 is fetched, then restart via redirect.
    do_reset();
    wait_fire_addr(32'h0000_3010, 40, "halt_fire_timeout");
    f_halt = 1'b1;
    k = 0;
    while (!halted && k < 10) begin step(); k++; end
    f0 = fires;
    repeat (10) step();
    chk("halt_no_req", fires - f0, 0);
    chk("halt_flag", halted, 1'b1);
    chk("halt_drained", out_valid, 1'b0);
    f_redir = 1'b1; f_redir_pc = 32'h0000_3000;
    step();
    step();
    popped.delete();
    wait_pops(1, 40, "restart_timeout");
    if (popped.size() >= 1) chk("restart_pc", popped[0], 32'h0000_3000);
    chk("restart_halted", halted, 1'b0);

    // Address wrap and misaligned redirect target.
    f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
    step();
    step();
    popped.delete();
    wait_pops(2, 40, "wrap_timeout");
    if (popped.size() >= 2) begin
      chk("wrap_pc0", popped[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", popped[1], 32'h0000_0000);
    end
    f_redir = 1'b1; f_redir_pc = 32'h0000_3043;
    step();
    step();
    f0 = fires;
    wait_fires(f0 + 1, 20, "align_timeout");
    chk("align_addr", last_fire_addr, 32'h0000_3040);

    // Random traffic with a reset in the middle.
    set_knobs(70, 60, 70, 3, 2);
    repeat (2500) step();
    do_reset();
    repeat (1500) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
